blk_add_arbiter: RTL and testbench
==================================

Name: blk_add_arbiter

Overview:
- Sequences and shares one combinational block-minifloat adder datapath (exponent-bias field plus LENGTH minifloats) between two requesters.
- Each request carries two blocks and an add/sub flag. The arbiter grants one request at a time, holds the operands stable on the datapath for LAT cycles (a multicycle path), captures the result and returns it on the granted requester's response channel.
- Sits between the block-level compute scheduler and the adder instance.

Parameters:
BIAS_W, 8, width of block exponent-bias field
LENGTH, 4, minifloats per block
SIZE, 8, bits per minifloat
LAT, 2, cycles operands are held before capture (>=1)
BLK_W, BIAS_W+LENGTH*SIZE, block width (derived, do not override)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 operation valid
req0_ready  out  1  requester 0 operation accepted
req0_a  in  BLK_W  requester 0 block A
req0_b  in  BLK_W  requester 0 block B
req0_sub  in  1  1 = A-B, 0 = A+B
resp0_valid  out  1  requester 0 result valid
resp0_ready  in  1  requester 0 result taken
resp0_data  out  BLK_W  requester 0 result block
req1_*/resp1_*  as above  requester 1 channels
dp_a  out  BLK_W  datapath operand A (registered)
dp_b  out  BLK_W  datapath operand B (registered)
dp_addsub  out  1  datapath sub flag (registered)
dp_out  in  BLK_W  datapath result (combinational from dp_*)
busy  out  1  state != IDLE
grant_id  out  1  requester currently/last granted

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; dp_a=0, dp_b=0, dp_addsub=0.
  - resp*_valid=0, resp*_data=0, busy=0.
  - grant_id=0; last-grant pointer=1, so req0 wins the first contention.
  - cnt=0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - sel = the only valid requester. If both are valid: round-robin, the requester != last grant.
  - reqN_ready = (state==IDLE) & (sel==N) & reqN_valid. Combinational; at most one ready high at a time.
  - On handshake: latch reqN_a/b/sub into dp_*; grant_id=N; pointer=N; cnt=LAT-1; go EXEC.
  - No valid: stay IDLE, all ready low.
- EXEC:
  - dp_* held constant.
  - If cnt==0: capture dp_out into resp{grant_id}_data, set resp{grant_id}_valid=1, go RESP. Otherwise decrement cnt.
- RESP:
  - resp_valid held and data stable until resp_ready is high at a clock edge. That edge clears valid and returns to IDLE.
  - The new grant happens at the earliest on the following cycle; no new request is accepted in RESP.
- Latency: handshake at edge T -> resp_valid high after edge T+LAT. With LAT=2 it is visible 2 cycles after acceptance.
- Throughput: 1 op per LAT+2 cycles minimum (handshake cycle + LAT + response cycle).
- resp_ready asserted while resp_valid is low is ignored.
- A requester dropping valid without ready: no state change.
- Non-granted requester's data is never sampled.
- Reset mid-EXEC/RESP: operation is discarded, no response issued, outputs go to reset values immediately.
- Response channel of the non-granted requester stays 0/unchanged.

Optional Feature:
- Macro BLKADD_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both are valid; pointer unused, grant_id still reports the grant.
- Undefined: round-robin as above.

Test Plan:
- Bench stub: dp_out = dp_a ^ dp_b.
- Reset, then req0_valid with a=40'h0A_3C_10_22_05, b=40'h0A_01_01_01_01, sub=0 -> req0_ready high same cycle; dp_addsub=0; resp0_valid after 2 edges with data 40'h00_3D_11_23_04; busy high throughout.
- req0 and req1 both valid continuously, resp_ready tied 1 -> grants alternate 0,1,0,1; each op 4 cycles apart; req1 sub=1 seen on dp_addsub=1.
- Same with BLKADD_FIXED_PRIO_EN -> only req0 granted while it stays valid; req1 granted only after req0_valid drops.
- resp0_ready held 0 for 5 cycles after resp0_valid -> data stable, req1_valid ignored (req1_ready=0), then accepted the cycle after resp0_ready=1.
- rst_n pulsed low during EXEC -> resp0_valid never rises; dp_a=0, busy=0 immediately; next request serviced normally with req0 priority.

Source files
------------

// File: rtl/blk_add_arbiter.sv
// blk_add_arbiter: shares one multicycle block-minifloat adder between two requesters.
// Define BLKADD_FIXED_PRIO_EN to give requester 0 fixed priority instead of round-robin.
module blk_add_arbiter #(
  parameter int BIAS_W = 8,
  parameter int LENGTH = 4,
  parameter int SIZE = 8,
  parameter int LAT = 2,
  localparam int BLK_W = BIAS_W + LENGTH * SIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [BLK_W-1:0] req0_a,
  input  logic [BLK_W-1:0] req0_b,
  input  logic             req0_sub,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [BLK_W-1:0] resp0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [BLK_W-1:0] req1_a,
  input  logic [BLK_W-1:0] req1_b,
  input  logic             req1_sub,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [BLK_W-1:0] resp1_data,
  output logic [BLK_W-1:0] dp_a,
  output logic [BLK_W-1:0] dp_b,
  output logic             dp_addsub,
  input  logic [BLK_W-1:0] dp_out,
  output logic             busy,
  output logic             grant_id
);
  localparam int CNT_W = LAT > 1 ? $clog2(LAT) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic r_grant, r_resp0_valid, r_resp1_valid;
  logic [BLK_W-1:0] r_dp_a, r_dp_b, r_resp0_data, r_resp1_data;
  logic r_dp_addsub;
  logic w_sel, w_hs, w_done, w_taken;
`ifdef BLKADD_FIXED_PRIO_EN
  assign w_sel = ~req0_valid;
`else
  logic r_ptr;
  // On contention grant whoever was not served last.
  assign w_sel = (req0_valid & req1_valid) ? ~r_ptr : req1_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= 1'b1;
    else if (w_hs) r_ptr <= w_sel;
`endif
  assign w_hs = req0_ready | req1_ready;
  assign w_done = (r_state == EXEC) && (r_cnt == '0);
  assign w_taken = (r_state == RESP) && (r_grant ? resp1_ready : resp0_ready);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (w_hs ? EXEC : IDLE) :
             (r_state == EXEC) ? (w_done ? RESP : EXEC) :
             (r_state == RESP) ? (w_taken ? IDLE : RESP) : IDLE;
  end
  always_comb begin
    busy = r_state != IDLE;
    req0_ready = (r_state == IDLE) & ~w_sel & req0_valid;
    req1_ready = (r_state == IDLE) & w_sel & req1_valid;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_dp_a <= '0;
      r_dp_b <= '0;
      r_dp_addsub <= 1'b0;
      r_grant <= 1'b0;
      r_cnt <= '0;
    end else if (w_hs) begin
      r_dp_a <= w_sel ? req1_a : req0_a;
      r_dp_b <= w_sel ? req1_b : req0_b;
      r_dp_addsub <= w_sel ? req1_sub : req0_sub;
      r_grant <= w_sel;
      r_cnt <= CNT_W'(LAT - 1);
    end else if (r_state == EXEC && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
      r_resp0_data <= '0;
      r_resp1_data <= '0;
    end else if (w_done) begin
      if (r_grant) begin
        r_resp1_valid <= 1'b1;
        r_resp1_data <= dp_out;
      end else begin
        r_resp0_valid <= 1'b1;
        r_resp0_data <= dp_out;
      end
    end else if (w_taken) begin
      if (r_grant) r_resp1_valid <= 1'b0;
      else r_resp0_valid <= 1'b0;
    end
  assign dp_a = r_dp_a;
  assign dp_b = r_dp_b;
  assign dp_addsub = r_dp_addsub;
  assign grant_id = r_grant;
  assign resp0_valid = r_resp0_valid;
  assign resp1_valid = r_resp1_valid;
  assign resp0_data = r_resp0_data;
  assign resp1_data = r_resp1_data;
endmodule

// File: tb/tb_blk_add_arbiter.sv
// tb_blk_add_arbiter: directed bench for blk_add_arbiter with an XOR datapath stub.
module tb_blk_add_arbiter;
  localparam int BLK_W = 40;
  logic clk = 0, rst_n = 0;
  logic req0_valid = 0, req0_ready, req0_sub = 0, resp0_valid, resp0_ready = 0;
  logic req1_valid = 0, req1_ready, req1_sub = 0, resp1_valid, resp1_ready = 0;
  logic [BLK_W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [BLK_W-1:0] resp0_data, resp1_data, dp_a, dp_b, dp_out;
  logic dp_addsub, busy, grant_id;
  int n_cmp = 0, n_err = 0;
  localparam logic [BLK_W-1:0] A0 = 40'h0A_3C_10_22_05, B0 = 40'h0A_01_01_01_01;
  localparam logic [BLK_W-1:0] R0 = 40'h00_3D_11_23_04;
  localparam logic [BLK_W-1:0] A1 = 40'h11_22_33_44_55, B1 = 40'h01_02_03_04_05;
  localparam logic [BLK_W-1:0] R1 = 40'h10_20_30_40_50;
  blk_add_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sub(req0_sub), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_data(resp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sub(req1_sub), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_data(resp1_data),
    .dp_a(dp_a), .dp_b(dp_b), .dp_addsub(dp_addsub), .dp_out(dp_out),
    .busy(busy), .grant_id(grant_id)
  );
  assign dp_out = dp_a ^ dp_b;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    logic g;
`ifdef BLKADD_FIXED_PRIO_EN
    logic [3:0] exp_g = 4'b0000;
`else
    logic [3:0] exp_g = 4'b1010;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_dp_a", dp_a, 0);
    chk("rst_resp0_valid", resp0_valid, 0);
    chk("rst_grant", grant_id, 0);
    rst_n = 1;
    @(negedge clk);
    chk("idle_ready0", req0_ready, 0);
    req0_valid = 1; req0_a = A0; req0_b = B0; req0_sub = 0;
    #1 chk("hs_ready0", req0_ready, 1);
    chk("hs_ready1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 0;
    chk("ex_busy", busy, 1);
    chk("ex_dp_a", dp_a, A0);
    chk("ex_addsub", dp_addsub, 0);
    chk("ex_grant", grant_id, 0);
    chk("ex_resp0_valid", resp0_valid, 0);
    @(negedge clk);
    chk("ex2_resp0_valid", resp0_valid, 0);
    chk("ex2_busy", busy, 1);
    @(negedge clk);
    chk("rsp_valid", resp0_valid, 1);
    chk("rsp_data", resp0_data, R0);
    chk("rsp_busy", busy, 1);
    chk("rsp_other", resp1_valid, 0);
    req1_valid = 1; req1_a = A1; req1_b = B1; req1_sub = 1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("stall_ready1", req1_ready, 0);
      chk("stall_data", resp0_data, R0);
      chk("stall_valid", resp0_valid, 1);
      @(negedge clk);
    end
    resp0_ready = 1;
    @(negedge clk);
    resp0_ready = 0;
    chk("post_rsp_valid", resp0_valid, 0);
    chk("post_rsp_busy", busy, 0);
    #1 chk("post_rsp_ready1", req1_ready, 1);
    @(negedge clk);
    req1_valid = 0;
    chk("r1_grant", grant_id, 1);
    chk("r1_addsub", dp_addsub, 1);
    repeat (2) @(negedge clk);
    chk("r1_valid", resp1_valid, 1);
    chk("r1_data", resp1_data, R1);
    chk("r1_resp0_quiet", resp0_valid, 0);
    resp1_ready = 1;
    @(negedge clk);
    chk("r1_done", resp1_valid, 0);
    resp0_ready = 1;
    req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 4; k++) begin
      g = exp_g[k];
      #1 chk("rr_ready0", req0_ready, !g);
      chk("rr_ready1", req1_ready, g);
      @(negedge clk);
      chk("rr_grant", grant_id, g);
      chk("rr_addsub", dp_addsub, g);
      repeat (2) @(negedge clk);
      chk("rr_resp", g ? resp1_valid : resp0_valid, 1);
      chk("rr_resp_data", g ? resp1_data : resp0_data, g ? R1 : R0);
      @(negedge clk);
    end
    req0_valid = 0;
    #1 chk("drop0_ready1", req1_ready, 1);
    @(negedge clk);
    req1_valid = 0;
    chk("drop0_grant", grant_id, 1);
    repeat (3) @(negedge clk);
    chk("drop0_idle", busy, 0);
    req0_valid = 1;
    @(negedge clk);
    req0_valid = 0;
    chk("mid_busy", busy, 1);
    #2 rst_n = 0;
    #1 chk("mid_rst_dp_a", dp_a, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_grant", grant_id, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_no_resp", resp0_valid, 0);
      @(negedge clk);
    end
    req0_valid = 1; req1_valid = 1;
    #1 chk("after_rst_ready0", req0_ready, 1);
    chk("after_rst_ready1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    repeat (2) @(negedge clk);
    chk("after_rst_resp", resp0_valid, 1);
    chk("after_rst_data", resp0_data, R0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
